// File: rtl/bnn_dot_l1_cxu.sv
// Binary-neural-net dot-product CXU on the L1 interface: counts matching bit
// positions of two operands (XNOR-popcount), with an optional fixed-latency pipeline.
module bnn_dot_l1_cxu #(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_N_STATES  = 0,
  parameter int CXU_LAT       = 0,
  parameter int CXU_RESET_LAT = 0,
  parameter int CXU_FUNC_ID_W = 0,
  parameter int CXU_DATA_W    = 32,
  parameter int CXU_REQ_ID_W  = 6,
  parameter int CXU_INSN_W    = 32,
  parameter int CXU_STATUS_W  = 3
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    clk_en,
  input  logic                                                    req_valid,
  input  logic [CXU_REQ_ID_W-1:0]                                 req_id,
  input  logic [((CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1)-1:0]  req_cxu,
  input  logic                                                    req_state,
  input  logic [((CXU_FUNC_ID_W > 0) ? CXU_FUNC_ID_W : 1)-1:0]    req_func,
  input  logic [CXU_INSN_W-1:0]                                   req_insn,
  input  logic [CXU_DATA_W-1:0]                                   req_data0,
  input  logic [CXU_DATA_W-1:0]                                   req_data1,
  output logic                                                    resp_valid,
  output logic [CXU_REQ_ID_W-1:0]                                 resp_id,
  output logic [CXU_STATUS_W-1:0]                                 resp_status,
  output logic [CXU_DATA_W-1:0]                                   resp_data
);

  localparam int CNT_W = $clog2(CXU_DATA_W + 1);

  // Elaboration-time legality checks for the parameter set.
  if (CXU_N_STATES != 0) begin : g_bad_states
    $error("bnn_dot_l1_cxu is stateless: CXU_N_STATES must be 0");
  end
  if (CXU_LAT < 0 || CXU_LAT > 8) begin : g_bad_lat
    $error("bnn_dot_l1_cxu: CXU_LAT must be in 0..8");
  end
  if (CXU_DATA_W != 32 && CXU_DATA_W != 64) begin : g_bad_data_w
    $error("bnn_dot_l1_cxu: CXU_DATA_W must be 32 or 64");
  end
  if (CXU_RESET_LAT < 0) begin : g_bad_reset_lat
    $error("bnn_dot_l1_cxu: CXU_RESET_LAT must be non-negative");
  end

  // Selector, state, function and instruction fields do not alter the result.
  logic unused_req_fields;
  assign unused_req_fields = ^{req_cxu, req_state, req_func, req_insn};

  // ---------------------------------------------------------------------------
  // L0 core: XNOR then popcount, zero-extended to the data width.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] popcount(input logic [CXU_DATA_W-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < CXU_DATA_W; i++) begin
      acc = acc + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

  logic [CXU_DATA_W-1:0] match_bits;
  logic [CNT_W-1:0]      match_cnt;
  logic [CXU_DATA_W-1:0] core_result;

  assign match_bits  = ~(req_data0 ^ req_data1);
  assign match_cnt   = popcount(match_bits);
  assign core_result = {{(CXU_DATA_W-CNT_W){1'b0}}, match_cnt};

  assign resp_status = '0;

  // ---------------------------------------------------------------------------
  // L0->L1 adapter. Handshake: req_valid is a strobe accepted unconditionally on
  // every enabled edge (no ready); resp_valid is asserted for exactly the enabled
  // cycles that carry a result, and id/data are forced to 0 whenever it is low.
  // ---------------------------------------------------------------------------
  if (CXU_LAT == 0) begin : g_comb
    logic unused_seq;
    assign unused_seq = ^{clk, rst, clk_en};

    assign resp_valid = req_valid;
    assign resp_id    = req_valid ? req_id      : '0;
    assign resp_data  = req_valid ? core_result : '0;
  end else begin : g_pipe
    logic                    stage_valid [CXU_LAT];
    logic [CXU_REQ_ID_W-1:0] stage_id    [CXU_LAT];
    logic [CXU_DATA_W-1:0]   stage_data  [CXU_LAT];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < CXU_LAT; i++) begin
          stage_valid[i] <= 1'b0;
          stage_id[i]    <= '0;
          stage_data[i]  <= '0;
        end
      end else if (clk_en) begin
        // Bubbles enter with id/data cleared so idle outputs read as 0.
        stage_valid[0] <= req_valid;
        stage_id[0]    <= req_valid ? req_id      : '0;
        stage_data[0]  <= req_valid ? core_result : '0;
        for (int i = 1; i < CXU_LAT; i++) begin
          stage_valid[i] <= stage_valid[i-1];
          stage_id[i]    <= stage_id[i-1];
          stage_data[i]  <= stage_data[i-1];
        end
      end
    end

    assign resp_valid = stage_valid[CXU_LAT-1];
    assign resp_id    = stage_id[CXU_LAT-1];
    assign resp_data  = stage_data[CXU_LAT-1];
  end

endmodule

// File: tb/tb_bnn_dot_l1_cxu.sv
// Directed bench for bnn_dot_l1_cxu: combinational (32b), one-stage (64b) and
// two-stage (32b) instances sharing clock, reset and clk_en.
module tb_bnn_dot_l1_cxu;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic clk_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_failed;

  // ---------------- instance A: DATA_W=32, LAT=0 ----------------
  logic        a_req_valid;
  logic [5:0]  a_req_id;
  logic [0:0]  a_req_cxu;
  logic        a_req_state;
  logic [0:0]  a_req_func;
  logic [31:0] a_req_insn;
  logic [31:0] a_req_data0, a_req_data1;
  logic        a_resp_valid;
  logic [5:0]  a_resp_id;
  logic [2:0]  a_resp_status;
  logic [31:0] a_resp_data;

  bnn_dot_l1_cxu #(.CXU_DATA_W(32), .CXU_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(a_req_valid), .req_id(a_req_id), .req_cxu(a_req_cxu),
    .req_state(a_req_state), .req_func(a_req_func), .req_insn(a_req_insn),
    .req_data0(a_req_data0), .req_data1(a_req_data1),
    .resp_valid(a_resp_valid), .resp_id(a_resp_id),
    .resp_status(a_resp_status), .resp_data(a_resp_data)
  );

  // ---------------- instance B: DATA_W=64, LAT=1 ----------------
  logic        b_req_valid;
  logic [5:0]  b_req_id;
  logic [63:0] b_req_data0, b_req_data1;
  logic        b_resp_valid;
  logic [5:0]  b_resp_id;
  logic [2:0]  b_resp_status;
  logic [63:0] b_resp_data;

  bnn_dot_l1_cxu #(.CXU_DATA_W(64), .CXU_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(b_req_valid), .req_id(b_req_id), .req_cxu(1'b0),
    .req_state(1'b0), .req_func(1'b0), .req_insn(32'h0),
    .req_data0(b_req_data0), .req_data1(b_req_data1),
    .resp_valid(b_resp_valid), .resp_id(b_resp_id),
    .resp_status(b_resp_status), .resp_data(b_resp_data)
  );

  // ---------------- instance C: DATA_W=32, LAT=2 ----------------
  logic        c_req_valid;
  logic [5:0]  c_req_id;
  logic [31:0] c_req_data0, c_req_data1;
  logic        c_resp_valid;
  logic [5:0]  c_resp_id;
  logic [2:0]  c_resp_status;
  logic [31:0] c_resp_data;

  bnn_dot_l1_cxu #(.CXU_DATA_W(32), .CXU_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(c_req_valid), .req_id(c_req_id), .req_cxu(1'b1),
    .req_state(1'b1), .req_func(1'b1), .req_insn(32'hFFFF_FFFF),
    .req_data0(c_req_data0), .req_data1(c_req_data1),
    .resp_valid(c_resp_valid), .resp_id(c_resp_id),
    .resp_status(c_resp_status), .resp_data(c_resp_data)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lat0_case(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [5:0] id, input logic [31:0] exp_cnt);
    a_req_valid = 1'b1;
    a_req_id    = id;
    a_req_data0 = d0;
    a_req_data1 = d1;
    a_req_insn  = $urandom;
    a_req_func  = 1'(($urandom_range(0, 1)));
    a_req_cxu   = 1'(($urandom_range(0, 1)));
    a_req_state = 1'(($urandom_range(0, 1)));
    #1;
    check({tag, "_data"}, 64'(a_resp_data), 64'(exp_cnt));
    check({tag, "_valid"}, 64'(a_resp_valid), 64'd1);
    check({tag, "_id"}, 64'(a_resp_id), 64'(id));
  endtask

  task automatic c_drive(input logic v, input logic [5:0] id,
                         input logic [31:0] d0, input logic [31:0] d1);
    c_req_valid = v;
    c_req_id    = id;
    c_req_data0 = d0;
    c_req_data1 = d1;
  endtask

  task automatic c_expect(input string tag, input logic v, input logic [5:0] id,
                          input logic [31:0] cnt);
    check({tag, "_valid"}, 64'(c_resp_valid), 64'(v));
    check({tag, "_id"}, 64'(c_resp_id), 64'(id));
    check({tag, "_data"}, 64'(c_resp_data), 64'(cnt));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst      = 1'b0;
    clk_en   = 1'b1;
    a_req_valid = 1'b0; a_req_id = '0; a_req_cxu = '0; a_req_state = 1'b0;
    a_req_func  = '0;   a_req_insn = '0; a_req_data0 = '0; a_req_data1 = '0;
    b_req_valid = 1'b0; b_req_id = '0; b_req_data0 = '0; b_req_data1 = '0;
    c_drive(1'b1, 6'd33, 32'h0, 32'h0);

    // Requests offered during reset must not propagate.
    tick();
    tick();
    check("rst_lat2_valid", 64'(c_resp_valid), 64'd0);
    check("rst_lat2_data", 64'(c_resp_data), 64'd0);
    check("rst_lat1_valid", 64'(b_resp_valid), 64'd0);
    check("rst_status", 64'(c_resp_status), 64'd0);
    c_drive(1'b0, 6'd0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    check("post_rst_lat2_valid", 64'(c_resp_valid), 64'd0);

    // LAT=0, 32-bit combinational cases.
    lat0_case("l0_zero_zero", 32'h0000_0000, 32'h0000_0000, 6'd1,  32'd32);
    lat0_case("l0_ones_zero", 32'hFFFF_FFFF, 32'h0000_0000, 6'd2,  32'd0);
    lat0_case("l0_alt",       32'hAAAA_AAAA, 32'h5555_5555, 6'd3,  32'd0);
    lat0_case("l0_nibble",    32'h0F0F_0F0F, 32'h0000_0000, 6'd4,  32'd16);
    lat0_case("l0_equal",     32'h1234_5678, 32'h1234_5678, 6'd63, 32'd32);
    lat0_case("l0_one_bit",   32'h0000_0001, 32'h0000_0000, 6'd5,  32'd31);
    check("l0_status", 64'(a_resp_status), 64'd0);
    a_req_valid = 1'b0;
    #1;
    check("l0_idle_valid", 64'(a_resp_valid), 64'd0);
    check("l0_idle_id", 64'(a_resp_id), 64'd0);
    check("l0_idle_data", 64'(a_resp_data), 64'd0);

    // LAT=1, 64-bit.
    @(negedge clk);
    b_req_valid = 1'b1; b_req_id = 6'd10;
    b_req_data0 = 64'hFFFF_FFFF_FFFF_FFFF; b_req_data1 = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("l1_before_edge_valid", 64'(b_resp_valid), 64'd0);
    tick();
    check("l1_ones_valid", 64'(b_resp_valid), 64'd1);
    check("l1_ones_id", 64'(b_resp_id), 64'd10);
    check("l1_ones_data", b_resp_data, 64'd64);
    b_req_id = 6'd11;
    b_req_data0 = 64'h0000_0000_FFFF_FFFF; b_req_data1 = 64'h0;
    tick();
    check("l1_half_valid", 64'(b_resp_valid), 64'd1);
    check("l1_half_id", 64'(b_resp_id), 64'd11);
    check("l1_half_data", b_resp_data, 64'd32);
    b_req_valid = 1'b0; b_req_id = 6'd12;
    tick();
    check("l1_bubble_valid", 64'(b_resp_valid), 64'd0);
    check("l1_bubble_id", 64'(b_resp_id), 64'd0);
    check("l1_bubble_data", b_resp_data, 64'd0);

    // LAT=2 back-to-back: ids 1,2,3.
    c_drive(1'b1, 6'd1, 32'hFFFF_0000, 32'hFFFF_FFFF);
    tick();
    c_expect("b2b_c1", 1'b0, 6'd0, 32'd0);
    c_drive(1'b1, 6'd2, 32'h0000_0001, 32'h0000_0000);
    tick();
    c_expect("b2b_r1", 1'b1, 6'd1, 32'd16);
    c_drive(1'b1, 6'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();
    c_expect("b2b_r2", 1'b1, 6'd2, 32'd31);
    c_drive(1'b0, 6'd0, 32'h0, 32'h0);
    tick();
    c_expect("b2b_r3", 1'b1, 6'd3, 32'd32);
    tick();
    c_expect("b2b_idle", 1'b0, 6'd0, 32'd0);

    // LAT=2 stall: freeze three cycles with two requests in flight.
    c_drive(1'b1, 6'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    tick();
    c_drive(1'b1, 6'd5, 32'h8000_0000, 32'h0000_0000);
    tick();
    c_expect("stall_r4", 1'b1, 6'd4, 32'd0);
    clk_en = 1'b0;
    c_drive(1'b1, 6'd40, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      c_expect("stall_hold", 1'b1, 6'd4, 32'd0);
    end
    c_drive(1'b0, 6'd0, 32'h0, 32'h0);
    clk_en = 1'b1;
    tick();
    c_expect("stall_r5", 1'b1, 6'd5, 32'd31);
    tick();
    c_expect("stall_idle", 1'b0, 6'd0, 32'd0);

    // Asynchronous reset with two requests in flight.
    c_drive(1'b1, 6'd7, 32'h0000_0000, 32'h0000_0000);
    tick();
    c_drive(1'b1, 6'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    c_expect("pre_rst_r7", 1'b1, 6'd7, 32'd32);
    c_drive(1'b0, 6'd0, 32'h0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    c_expect("async_rst", 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    c_expect("no_stale_1", 1'b0, 6'd0, 32'd0);
    tick();
    c_expect("no_stale_2", 1'b0, 6'd0, 32'd0);
    c_drive(1'b1, 6'd9, 32'h0F0F_0F0F, 32'h0000_0000);
    tick();
    c_drive(1'b0, 6'd0, 32'h0, 32'h0);
    c_expect("new_req_wait", 1'b0, 6'd0, 32'd0);
    tick();
    c_expect("new_req_r9", 1'b1, 6'd9, 32'd16);
    check("lat2_status", 64'(c_resp_status), 64'd0);
    check("lat1_status", 64'(b_resp_status), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
